// File: rtl/quant_dot_engine.sv
// Multi-lane quantized dot-product engine: Q16.16 activations x integer weights,
// per-lane accumulate, then arithmetic right-shift requant. Define QDOT_SAT_EN for clamping.
module quant_dot_engine #(
  parameter int VEC_LEN = 8,
  parameter int X_W     = 32,
  parameter int W_W     = 8,
  parameter int CH      = 4,
  parameter int ACC_W   = 48,
  parameter int SHIFT_W = 5
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                start_i,
  input  logic [SHIFT_W-1:0]  shift_i,
  input  logic                x_valid_i,
  input  logic [X_W-1:0]      vector_x_i,
  input  logic [CH*W_W-1:0]   quant_w_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [CH*X_W-1:0]   dout_o,
  output logic [CH-1:0]       sat_o
);

  localparam int CNT_W = $clog2(VEC_LEN);
  localparam int P_W   = X_W + W_W;

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [SHIFT_W-1:0]        shift_q, shift_d;
  logic signed [ACC_W-1:0]   acc_q [CH];
  logic signed [ACC_W-1:0]   acc_d [CH];
  logic signed [P_W-1:0]     prod  [CH];
  logic [CH*X_W-1:0]         dout_q, dout_d;
  logic                      done_q, done_d;
  logic                      accept, last;

  assign accept = (state_q == ACCUM) && x_valid_i;
  assign last   = accept && (cnt_q == CNT_W'(VEC_LEN - 1));

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = ACCUM;
      ACCUM:   if (last)    state_d = SCALE;
      SCALE:                state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_o = (state_q != IDLE);
  end

  // Full-precision products: both operands sign-extended to the product width first.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      prod[c] = $signed({{W_W{vector_x_i[X_W-1]}}, vector_x_i})
              * $signed({{X_W{quant_w_i[c*W_W+W_W-1]}}, quant_w_i[c*W_W +: W_W]});
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    for (int c = 0; c < CH; c++) acc_d[c] = acc_q[c];
    if (state_q == IDLE && start_i) begin
      cnt_d   = '0;
      shift_d = shift_i;
      for (int c = 0; c < CH; c++) acc_d[c] = '0;
    end else if (accept) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
      for (int c = 0; c < CH; c++)
        acc_d[c] = acc_q[c] + {{(ACC_W-P_W){prod[c][P_W-1]}}, prod[c]};
    end
  end

`ifdef QDOT_SAT_EN
  localparam logic [X_W-1:0] MAX_V = {1'b0, {(X_W-1){1'b1}}};
  localparam logic [X_W-1:0] MIN_V = {1'b1, {(X_W-1){1'b0}}};

  logic signed [ACC_W-1:0] r_full [CH];
  logic [ACC_W-X_W:0]      r_hi   [CH];
  logic [CH-1:0]           sat_q, sat_d;

  always_comb begin
    dout_d = dout_q;
    sat_d  = sat_q;
    done_d = 1'b0;
    for (int c = 0; c < CH; c++) begin
      r_full[c] = acc_q[c] >>> shift_q;
      r_hi[c]   = r_full[c][ACC_W-1:X_W-1];
    end
    if (state_q == SCALE) begin
      done_d = 1'b1;
      for (int c = 0; c < CH; c++) begin
        // The value fits X_W bits only if the sign bit and everything above agree.
        if (&r_hi[c] || ~|r_hi[c]) begin
          dout_d[c*X_W +: X_W] = r_full[c][X_W-1:0];
          sat_d[c]             = 1'b0;
        end else begin
          dout_d[c*X_W +: X_W] = r_full[c][ACC_W-1] ? MIN_V : MAX_V;
          sat_d[c]             = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sat_q <= '0;
    else         sat_q <= sat_d;
  end

  assign sat_o = sat_q;
`else
  always_comb begin
    dout_d = dout_q;
    done_d = 1'b0;
    if (state_q == SCALE) begin
      done_d = 1'b1;
      for (int c = 0; c < CH; c++)
        dout_d[c*X_W +: X_W] = X_W'(acc_q[c] >>> shift_q);
    end
  end

  assign sat_o = '0;
`endif

  // NOTE: the per-lane accumulator array is reset explicitly so a mid-vector reset discards partial sums.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      for (int c = 0; c < CH; c++) acc_q[c] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      for (int c = 0; c < CH; c++) acc_q[c] <= acc_d[c];
    end
  end

  assign dout_o = dout_q;
  assign done_o = done_q;

endmodule
